// File: rtl/wired_line_pkg.sv
// Shared types and defaults for the wired-line receiver.
//   state_t  : receiver FSM states
//   pulse_t  : classification of a completed low pulse
//   classify : maps a low-pulse width (cycles) onto pulse_t
package wired_line_pkg;

  localparam int BIT_THRESH_DEF   = 16;
  localparam int RESET_THRESH_DEF = 64;
  localparam int IDLE_TIMEOUT_DEF = 128;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  typedef enum logic [1:0] {BIT0, BIT1, BUS_RST} pulse_t;

  function automatic pulse_t classify(input int unsigned w,
                                      input int unsigned bit_th,
                                      input int unsigned rst_th);
    pulse_t p;
    if (w >= rst_th)      p = BUS_RST;
    else if (w >= bit_th) p = BIT0;
    else                  p = BIT1;
    return p;
  endfunction

endpackage

// File: rtl/wired_line_filter.sv
// Synchronizer plus run-length glitch filter for the wired line.
//   clk, rst : clock, synchronous active-high reset
//   line_s   : resolved 0/1 line level (asynchronous)
//   level    : filtered level (resets to 1 = idle)
//   rise/fall: one-cycle strobes, asserted in the first cycle of the new level
//   raw      : synchronized, unfiltered sample
//   primed   : high once the synchronizer holds real samples rather than preload
module wired_line_filter
  import wired_line_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_s,
  output logic level,
  output logic rise,
  output logic fall,
  output logic raw,
  output logic primed
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] prime_sr;
  logic [FW-1:0]          run;

  assign raw    = sync[SYNC_STAGES-1];
  assign primed = prime_sr[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '1;
      prime_sr <= '0;
      run      <= '0;
      level    <= 1'b1;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], line_s};
      prime_sr <= {prime_sr[SYNC_STAGES-2:0], 1'b1};
      rise     <= 1'b0;
      fall     <= 1'b0;
      // run counts consecutive samples disagreeing with level; the
      // FILTER_LEN-th one flips the level
      if (raw != level) begin
        if (run == FW'(FILTER_LEN - 1)) begin
          level <= raw;
          run   <= '0;
          rise  <= raw;
          fall  <= ~raw;
        end else begin
          run <= run + FW'(1);
        end
      end else begin
        run <= '0;
      end
    end
  end

endmodule

// File: rtl/wired_line_rx.sv
// Wired-line receiver: filters the line, classifies low pulses by width as
// bit 1 / bit 0 / bus reset, assembles LSB-first words, valid/ready output.
//   clk, rst     : clock, synchronous active-high reset
//   line_i       : wired line, idle high
//   data_o       : received word (LSB = first bit)
//   valid_o      : data_o holds an unconsumed word
//   ready_i      : consumer accepts when valid_o & ready_i
//   bus_reset_o  : one-cycle pulse per bus reset
//   frame_err_o  : one-cycle pulse when a partial word is dropped on idle
//   overrun_o    : sticky, a word completed while the previous one was pending
// Optional macro WIRED_LINE_PULL_EN: resolve the line through a pull-up net
// (simulation only); otherwise z/x samples map to 1 explicitly.
module wired_line_rx
  import wired_line_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 3,
  parameter int BIT_THRESH   = BIT_THRESH_DEF,
  parameter int RESET_THRESH = RESET_THRESH_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              bus_reset_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  localparam int BCW = $clog2(DATA_W + 1);

  logic line_s;
`ifdef WIRED_LINE_PULL_EN
  wire (pull1, highz0) line_n = 1'b1;
  assign line_n = line_i;
  assign line_s = line_n;
`else
  assign line_s = (line_i === 1'b0) ? 1'b0 : 1'b1;
`endif

  logic level, rise, fall, raw, primed;

  wired_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .line_s(line_s),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .raw   (raw),
    .primed(primed)
  );

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] sreg, word;
  // Cleared by reset, set once a real high sample is seen. A reset landing
  // inside a low pulse must not decode the tail of that pulse as a bit.
  logic              armed;

  logic shift, bit_val, bus_rst, drop, word_done, timeout;
  logic [CNT_W:0] width;
  pulse_t kind;

  // cnt counts cycles after the edge cycle, so width includes the edge cycle
  assign width     = {1'b0, cnt} + (CNT_W+1)'(1);
  assign kind      = classify(32'(width), BIT_THRESH, RESET_THRESH);
  assign timeout   = (width == (CNT_W+1)'(IDLE_TIMEOUT));
  assign word      = {bit_val, sreg[DATA_W-1:1]};
  assign word_done = shift && (bit_cnt == BCW'(DATA_W - 1));

  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    bit_val   = 1'b0;
    bus_rst   = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: if (fall && armed) state_nxt = LOW;
      LOW: begin
        if (rise) begin
          case (kind)
            BUS_RST: begin bus_rst = 1'b1; state_nxt = IDLE; end
            BIT0:    begin shift = 1'b1; bit_val = 1'b0; state_nxt = HIGH; end
            default: begin shift = 1'b1; bit_val = 1'b1; state_nxt = HIGH; end
          endcase
        end
      end
      HIGH: begin
        if (fall) begin
          state_nxt = LOW;
        end else if (timeout) begin
          drop      = (bit_cnt != '0);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      sreg        <= '0;
      armed       <= 1'b0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      bus_reset_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      armed       <= armed | (primed & raw);
      bus_reset_o <= bus_rst;
      frame_err_o <= drop;

      if (rise || fall)                      cnt <= '0;
      else if (state != IDLE && cnt != '1)   cnt <= cnt + CNT_W'(1);

      if (bus_rst) begin
        bit_cnt <= '0;
        sreg    <= '0;
      end else if (drop) begin
        bit_cnt <= '0;
      end else if (shift) begin
        sreg    <= word;
        bit_cnt <= word_done ? '0 : bit_cnt + BCW'(1);
      end

      if (valid_o && ready_i) valid_o <= 1'b0;
      // a word completing in the handshake cycle replaces the consumed one
      if (word_done) begin
        if (!valid_o || ready_i) begin
          data_o  <= word;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wired_line_rx.sv
module tb_wired_line_rx;
  localparam int S  = 2;
  localparam int F  = 3;
  localparam int BT = 16;
  localparam int RT = 64;
  localparam int TO = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_i = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, bus_reset_o, frame_err_o, overrun_o;

  wired_line_rx dut (
    .clk(clk), .rst(rst), .line_i(line_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .bus_reset_o(bus_reset_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_br = 0;
  int n_fe = 0;
  int fe_cyc = 0;
  bit rand_ready = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // observe outputs mid-cycle; inputs only change just after posedge
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o && ready_i) got_q.push_back(data_o);
      if (bus_reset_o) n_br++;
      if (frame_err_o) begin n_fe++; fe_cyc = cyc; end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired got no_finish exp finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic pulse(input int lo, input int hi);
    line_i = 1'b0; tick(lo);
    line_i = 1'b1; tick(hi);
  endtask

  task automatic send_word(input logic [7:0] w, input int w1, input int w0, input int gap);
    for (int i = 0; i < 8; i++) pulse(w[i] ? w1 : w0, gap);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete(); n_br = 0; n_fe = 0;
  endtask

  function automatic int first_got();
    return (got_q.size() > 0) ? int'(got_q[0]) : -1;
  endfunction

  typedef struct {
    logic [7:0] word;
    int         w1;
    int         w0;
    int         gap;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c0;
    int widths[$];
    logic [7:0] exp_q[$];
    logic [7:0] acc;
    int nb, exp_br;

    vecs[0] = '{8'hA5,  8, 32,  10, 8'hA5};
    vecs[1] = '{8'hFF, 15, 16,   6, 8'hFF};  // just below bit-0 threshold
    vecs[2] = '{8'h00,  4, 63,   6, 8'h00};  // just below bus-reset threshold
    vecs[3] = '{8'h5A, 15, 16,   4, 8'h5A};
    vecs[4] = '{8'h81,  4, 63, 120, 8'h81};  // long gaps, under the timeout
    vecs[5] = '{8'hC3, 10, 40,  20, 8'hC3};

    // reset state
    tick(3);
    chk("rst_data",  int'(data_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_busrst", int'(bus_reset_o), 0);
    chk("rst_ferr",  int'(frame_err_o), 0);
    chk("rst_ovr",   int'(overrun_o), 0);
    rst = 1'b0;
    tick(6);

    // table of words, consumer always ready
    ready_i = 1'b1;
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      send_word(vecs[v].word, vecs[v].w1, vecs[v].w0, vecs[v].gap);
      tick(12);
      chk($sformatf("vec%0d_beats", v), got_q.size(), 1);
      chk($sformatf("vec%0d_data", v), first_got(), int'(vecs[v].exp));
      chk($sformatf("vec%0d_err", v), n_br + n_fe, 0);
      chk($sformatf("vec%0d_ovr", v), int'(overrun_o), 0);
    end

    // short glitch is invisible (an accepted one would time out as a frame error)
    clear_mon();
    pulse(2, 160);
    chk("glitch_beats", got_q.size(), 0);
    chk("glitch_br", n_br, 0);
    chk("glitch_fe", n_fe, 0);

    // bus reset mid-word, then a clean word
    clear_mon();
    pulse(8, 10); pulse(32, 10); pulse(8, 10);
    pulse(80, 10);
    chk("busrst_count", n_br, 1);
    chk("busrst_beats", got_q.size(), 0);
    send_word(8'h3C, 8, 32, 10);
    tick(12);
    chk("busrst_next_beats", got_q.size(), 1);
    chk("busrst_next_data", first_got(), 8'h3C);

    // partial word dropped on idle timeout
    clear_mon();
    pulse(8, 10); pulse(32, 10); pulse(8, 10); pulse(32, 10);
    line_i = 1'b0; tick(8);
    line_i = 1'b1; c0 = cyc;
    tick(200);
    chk("ferr_count", n_fe, 1);
    chk("ferr_time", int'(fe_cyc >= c0 + TO && fe_cyc <= c0 + TO + S + F + 3), 1);
    chk("ferr_valid", int'(valid_o), 0);
    chk("ferr_beats", got_q.size(), 0);

    // overrun: second word lost while the first is held
    clear_mon();
    ready_i = 1'b0;
    send_word(8'h11, 8, 32, 10);
    send_word(8'h22, 8, 32, 10);
    tick(10);
    chk("ovr_valid", int'(valid_o), 1);
    chk("ovr_data", int'(data_o), 8'h11);
    chk("ovr_flag", int'(overrun_o), 1);
    ready_i = 1'b1;
    tick(5);
    chk("ovr_beats", got_q.size(), 1);
    chk("ovr_beat_data", first_got(), 8'h11);
    chk("ovr_valid_after", int'(valid_o), 0);
    chk("ovr_sticky", int'(overrun_o), 1);

    // reset in the middle of a bit-0 pulse
    clear_mon();
    pulse(8, 10); pulse(8, 10);
    line_i = 1'b0; tick(16);
    rst = 1'b1; tick(1);
    chk("midrst_valid", int'(valid_o), 0);
    chk("midrst_data", int'(data_o), 0);
    chk("midrst_ovr", int'(overrun_o), 0);
    rst = 1'b0;
    tick(16);
    line_i = 1'b1; tick(20);
    send_word(8'h96, 8, 32, 10);
    tick(12);
    chk("midrst_beats", got_q.size(), 1);
    chk("midrst_word", first_got(), 8'h96);
    chk("midrst_fe", n_fe, 0);

`ifdef WIRED_LINE_PULL_EN
    // floating line resolves high through the pull
    clear_mon();
    line_i = 1'bz; tick(50);
    chk("pull_z_beats", got_q.size(), 0);
    chk("pull_z_br", n_br + n_fe, 0);
    line_i = 1'b0; tick(8);
    line_i = 1'bz; tick(10);
    for (int i = 1; i < 8; i++) begin
      line_i = 1'b0; tick(32);
      line_i = 1'bz; tick(10);
    end
    tick(12);
    chk("pull_word", first_got(), 8'h01);
    line_i = 1'b1;
`endif

    // randomized pulse stream against a width-rule model
    clear_mon();
    exp_br = 0;
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5)       widths.push_back($urandom_range(RT, RT + 30));
      else if (r < 52) widths.push_back($urandom_range(4, BT - 1));
      else             widths.push_back($urandom_range(BT, RT - 1));
    end
    acc = '0; nb = 0;
    foreach (widths[i]) begin
      if (widths[i] >= RT) begin
        nb = 0; exp_br++;
      end else begin
        acc[nb] = (widths[i] < BT);
        nb++;
        if (nb == 8) begin exp_q.push_back(acc); nb = 0; end
      end
    end
    rand_ready = 1'b1;
    foreach (widths[i]) pulse(widths[i], $urandom_range(4, 40));
    tick(200);
    rand_ready = 1'b0;
    ready_i = 1'b1;
    tick(4);
    chk("rnd_beats", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rnd_word%0d", i), int'(got_q[i]), int'(exp_q[i]));
    chk("rnd_br", n_br, exp_br);
    chk("rnd_fe", n_fe, int'(nb != 0));
    chk("rnd_ovr", int'(overrun_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
